// File: rtl/fwrisc_prefetch.sv
// Instruction prefetch queue: sequential word fetches ahead of execution into a
// DEPTH-entry circular queue, with redirect flush and stale-response discard.
module fwrisc_prefetch #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   output logic [31:0]            iaddr,
   output logic                   ivalid,
   input  logic                   iready,
   input  logic [31:0]            idata,
   output logic                   fetch_valid,
   output logic [31:0]            fetch_pc,
   output logic [31:0]            fetch_data,
   input  logic                   fetch_ready,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;
   localparam logic [PW-1:0] DEPTH_M1 = PW'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DROP
   } state_t;

   state_t        r_state, w_state_n;
   logic [31:0]   r_iaddr, w_iaddr_n;
   logic [31:0]   r_target, w_target_n;
   logic          r_ivalid;
   logic [PW-1:0] r_rd_ptr, r_wr_ptr, r_count;
   logic [PW-1:0] w_rd_ptr_n, w_wr_ptr_n, w_count_n, w_count_after_pop;
   logic          r_fetch_valid, w_fetch_valid_n;
   logic [31:0]   r_fetch_pc, w_fetch_pc_n;
   logic [31:0]   r_fetch_data, w_fetch_data_n;
   logic [31:0]   r_mem_pc   [DEPTH];
   logic [31:0]   r_mem_data [DEPTH];
   logic          w_push, w_pop, w_flush;
   logic [31:0]   w_redir_addr;

   assign w_redir_addr      = redirect_pc & 32'hFFFF_FFFC;
   assign w_pop             = r_fetch_valid && fetch_ready && !redirect;
   assign w_count_after_pop = r_count - PW'(w_pop);

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_n;
   end

   // Next state, request address, redirect target and push decision
   always_comb begin
      w_state_n  = r_state;
      w_iaddr_n  = r_iaddr;
      w_target_n = r_target;
      w_push     = 1'b0;
      w_flush    = 1'b0;
      if (redirect) begin
         w_flush = 1'b1;
         // An un-accepted request cannot be withdrawn: wait it out in DROP
         if ((r_state == ST_REQ || r_state == ST_DROP) && !iready) begin
            w_state_n  = ST_DROP;
            w_target_n = w_redir_addr;
         end else begin
            w_state_n = ST_REQ;
            w_iaddr_n = w_redir_addr;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_count_after_pop <= DEPTH_M1) w_state_n = ST_REQ;
            end
            ST_REQ: begin
               if (iready) begin
                  w_push    = 1'b1;
                  w_iaddr_n = r_iaddr + 32'd4;
                  w_state_n = (w_count_after_pop < DEPTH_M1) ? ST_REQ : ST_IDLE;
               end
            end
            ST_DROP: begin
               if (iready) begin
                  w_iaddr_n = r_target;
                  w_state_n = ST_REQ;
               end
            end
            default: w_state_n = ST_IDLE;
         endcase
      end
   end

   // Queue pointers and head-register next values (push bypasses into an empty head)
   always_comb begin
      w_rd_ptr_n      = r_rd_ptr + PW'(w_pop);
      w_wr_ptr_n      = r_wr_ptr + PW'(w_push);
      w_count_n       = w_count_after_pop + PW'(w_push);
      w_fetch_valid_n = (w_count_n != '0);
      w_fetch_pc_n    = r_fetch_pc;
      w_fetch_data_n  = r_fetch_data;
      if (w_flush) begin
         w_rd_ptr_n      = '0;
         w_wr_ptr_n      = '0;
         w_count_n       = '0;
         w_fetch_valid_n = 1'b0;
      end else if (w_push && w_count_after_pop == '0) begin
         w_fetch_pc_n   = r_iaddr;
         w_fetch_data_n = idata;
      end else if (w_count_n != '0) begin
         w_fetch_pc_n   = r_mem_pc[w_rd_ptr_n[IW-1:0]];
         w_fetch_data_n = r_mem_data[w_rd_ptr_n[IW-1:0]];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_iaddr       <= RESET_ADDR;
         r_target      <= RESET_ADDR;
         r_ivalid      <= 1'b0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_fetch_valid <= 1'b0;
         r_fetch_pc    <= '0;
         r_fetch_data  <= '0;
      end else begin
         r_iaddr       <= w_iaddr_n;
         r_target      <= w_target_n;
         r_ivalid      <= (w_state_n != ST_IDLE);
         r_rd_ptr      <= w_rd_ptr_n;
         r_wr_ptr      <= w_wr_ptr_n;
         r_count       <= w_count_n;
         r_fetch_valid <= w_fetch_valid_n;
         r_fetch_pc    <= w_fetch_pc_n;
         r_fetch_data  <= w_fetch_data_n;
      end
   end

   // Queue storage
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr[IW-1:0]]   <= r_iaddr;
         r_mem_data[r_wr_ptr[IW-1:0]] <= idata;
      end
   end

   assign iaddr       = r_iaddr;
   assign ivalid      = r_ivalid;
   assign fetch_valid = r_fetch_valid;
   assign fetch_pc    = r_fetch_pc;
   assign fetch_data  = r_fetch_data;
   assign count       = r_count;

endmodule
